// File: rtl/pipe_adder.sv
// Segmented carry-chain adder/subtractor with valid/ready flow control.
// Optional build macro PIPE_ADDER_SAT_EN adds signed saturation of the result.
module pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO   = k * SEG_W;
    localparam int HI   = (LO + SEG_W > WIDTH) ? WIDTH - 1 : LO + SEG_W - 1;
    localparam int SW   = HI - LO + 1;
    // Lowest operand bit still needed downstream; the last stage keeps only the MSB for ovf.
    localparam int KEEP = (HI + 1 < WIDTH) ? HI + 1 : WIDTH - 1;

    logic [WIDTH-1:LO]   a_in;
    logic [WIDTH-1:LO]   bp_in;
    logic                c_in;
    logic                v_in;
    logic [SW:0]         seg;
    logic [HI:0]         s_nxt;
    logic [WIDTH-1:KEEP] a_q;
    logic [WIDTH-1:KEEP] bp_q;
    logic [HI:0]         s_q;
    logic                c_q;
    logic                v_q;

    assign seg = {1'b0, a_in[HI:LO]} + {1'b0, bp_in[HI:LO]} + {{SW{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign a_in  = a;
      assign bp_in = sub ? ~b : b;
      assign c_in  = sub ^ cin;
      assign v_in  = in_valid;
      assign s_nxt = seg[SW-1:0];
    end else begin : g_body
      assign a_in  = g_stg[k-1].a_q;
      assign bp_in = g_stg[k-1].bp_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign s_nxt = {seg[SW-1:0], g_stg[k-1].s_q};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        a_q  <= '0;
        bp_q <= '0;
        s_q  <= '0;
      end else if (en) begin
        v_q  <= v_in;
        c_q  <= seg[SW];
        a_q  <= a_in[WIDTH-1:KEEP];
        bp_q <= bp_in[WIDTH-1:KEEP];
        s_q  <= s_nxt;
      end
    end
  end

  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             bp_msb;

  assign raw       = g_stg[NSEG-1].s_q;
  assign a_msb     = g_stg[NSEG-1].a_q[WIDTH-1];
  assign bp_msb    = g_stg[NSEG-1].bp_q[WIDTH-1];
  assign out_valid = g_stg[NSEG-1].v_q;
  assign cout      = g_stg[NSEG-1].c_q;
  assign ovf       = (a_msb == bp_msb) && (raw[WIDTH-1] != a_msb);

`ifdef PIPE_ADDER_SAT_EN
  // Clamp toward the sign of a: 0111..1 for positive overflow, 1000..0 for negative.
  assign sum = ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: vector table, backpressure, async reset, 3-stage build.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  logic       in_valid10, in_ready10, cin10, sub10, out_valid10, out_ready10, cout10, ovf10;
  logic [9:0] a10, b10, sum10;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s_wrap;
    logic [7:0] s_sat;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl[14];
  logic [9:0] q[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .SEG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(10), .SEG_W(4)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
    .a(a10), .b(b10), .cin(cin10), .sub(sub10), .out_valid(out_valid10),
    .out_ready(out_ready10), .sum(sum10), .cout(cout10), .ovf(ovf10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef PIPE_ADDER_SAT_EN
    return v.s_sat;
`else
    return v.s_wrap;
`endif
  endfunction

  // Reference: {ovf, cout, sum} from full-width arithmetic.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mc, input logic ms);
    logic [7:0] bp;
    logic [8:0] full;
    logic [7:0] s;
    logic       v;
    bp   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bp} + {8'd0, ms ? ~mc : mc};
    s    = full[7:0];
    v    = (ma[7] == bp[7]) && (s[7] != ma[7]);
`ifdef PIPE_ADDER_SAT_EN
    if (v) s = ma[7] ? 8'h80 : 8'h7F;
`endif
    return {v, full[8], s};
  endfunction

  task automatic run_stream(input int n, input bit rnd, input string tag);
    int sent  = 0;
    int got   = 0;
    int stall = 0;
    int cyc   = 0;
    bit seen  = 0;
    logic [9:0] e;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!rnd && !seen && out_valid) begin
        seen  = 1;
        stall = 3;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : (stall == 0);
      if (sent < n && (!rnd || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        if (rnd) begin
          a = 8'($urandom); b = 8'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
        end else begin
          a = 8'(sent * 37 + 3); b = 8'(sent * 91 + 200);
          cin = sent[0]; sub = sent[1];
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall > 0) begin
        chk({tag, "_stall_in_ready"}, in_ready, 0);
        chk({tag, "_stall_out_valid"}, out_valid, 1);
        stall--;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_spurious: out_valid=1 with nothing in flight", tag);
        end else begin
          e = q[0];
          chk({tag, "_sum"}, sum, e[7:0]);
          chk({tag, "_cout"}, cout, e[8]);
          chk({tag, "_ovf"}, ovf, e[9]);
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_delivered"}, got, n);
    chk({tag, "_leftover"}, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    tbl[1]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    tbl[3]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
    tbl[4]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 8'h47, 1'b0, 1'b0};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
    tbl[7]  = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0};
    tbl[8]  = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0};
    tbl[9]  = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 8'h7F, 1'b0, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[11] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[12] = '{8'h80, 8'h7F, 1'b0, 1'b1, 8'h01, 8'h80, 1'b1, 1'b1};
    tbl[13] = '{8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid10 = 1'b0; a10 = '0; b10 = '0; cin10 = 1'b0; sub10 = 1'b0; out_ready10 = 1'b1;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid10", out_valid10, 0);
    chk("rst_in_ready10", in_ready10, 1);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table: result for vector j-2 is visible before edge j.
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        chk("tbl_out_valid", out_valid, 1);
        chk("tbl_sum", sum, pick(tbl[j-2]));
        chk("tbl_cout", cout, tbl[j-2].cout);
        chk("tbl_ovf", ovf, tbl[j-2].ovf);
      end else begin
        chk("tbl_latency", out_valid, 0);
      end
      if (j < 14) begin
        in_valid = 1'b1;
        a = tbl[j].a; b = tbl[j].b; cin = tbl[j].cin; sub = tbl[j].sub;
      end else begin
        in_valid = 1'b0;
      end
    end

    run_stream(5, 1'b0, "bp");
    run_stream(300, 1'b1, "rnd");

    // Async reset with two transactions in flight.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h21; b = 8'h11; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = 8'h42; b = 8'h13;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_sum", sum, 8'h32);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_in_ready", in_ready, 1);
    in_valid = 1'b1; a = 8'h55; b = 8'h01;
    @(negedge clk);
    @(negedge clk);
    chk("in_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_latency", out_valid, 0);
    @(negedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_sum", sum, 8'h10);
    chk("post_rst_cout", cout, 0);
    chk("post_rst_ovf", ovf, 0);
    @(negedge clk);
    #1;
    chk("post_rst_no_stray", out_valid, 0);

    // Three-stage build: 0x3FF + 0x001 ripples through every segment.
    @(negedge clk);
    in_valid10 = 1'b1; a10 = 10'h3FF; b10 = 10'h001; cin10 = 1'b0; sub10 = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      in_valid10 = 1'b0;
      #1;
      if (e < 3) begin
        chk("w10_latency", out_valid10, 0);
      end else begin
        chk("w10_out_valid", out_valid10, 1);
        chk("w10_sum", sum10, 10'h000);
        chk("w10_cout", cout10, 1);
        chk("w10_ovf", ovf10, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
